// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_divider_pkg;

  // Default divisor/remainder width; dividend and quotient are twice this.
  localparam int W_DEFAULT = 4;

  // Default dividend/quotient width (2W).
  localparam int DW_DEFAULT = 2 * W_DEFAULT;

  // Default step-counter width: enough to count 0 .. 2W-1.
  localparam int CNT_W_DEFAULT = $clog2(DW_DEFAULT);

  // Controller states: waiting for work, shifting quotient bits, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step-counter width for an arbitrary W, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (2 * w > 2) ? $clog2(2 * w) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it did not borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W:0]   r_in,
  input  logic         q_msb,
  input  logic [W-1:0] divisor,
  output logic [W:0]   r_out,
  output logic         q_bit
);

  logic [W:0] r_shift;
  logic [W:0] diff;
  logic       borrow;

  // The incoming partial remainder is always below the divisor, so its top bit
  // is zero and shifting it out loses nothing.
  logic       r_msb_unused;
  assign r_msb_unused = r_in[W];

  // Shift, subtract with a borrow-out, then restore when the subtract underflowed.
  always_comb begin
    r_shift          = {r_in[W-1:0], q_msb};
    {borrow, diff}   = {1'b0, r_shift} - {2'b00, divisor};
    q_bit            = ~borrow;
    r_out            = borrow ? r_shift : diff;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, valid/ready handshakes on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*W-1:0]  dividend,
  input  logic [W-1:0]    divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  quotient,
  output logic [W-1:0]    remainder,
  output logic            div_by_zero
);

  localparam int DW    = 2 * W;
  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DW - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       r_q, r_d;
  logic [DW-1:0]    q_q, q_d;
  logic [W-1:0]     div_q, div_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [W:0]       step_r;
  logic             step_bit;

  div_step #(.W(W)) u_step (
    .r_in    (r_q),
    .q_msb   (q_q[DW-1]),
    .divisor (div_q),
    .r_out   (step_r),
    .q_bit   (step_bit)
  );

  // Next-state logic: accept in IDLE, one restoring step per cycle in RUN,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    div_d       = div_q;
    dbz_d       = dbz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d      = divisor;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            q_d         = '1;
            r_d         = {1'b0, dividend[W-1:0]};
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            q_d     = dividend;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = step_r;
        q_d   = {q_q[DW-2:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      div_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      div_q       <= div_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = q_q;
  assign remainder   = r_q[W-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: an arithmetic reference model compared
// every cycle, directed literal cases, and an exhaustive sweep with random stalls.
module tb_seq_divider;

  localparam int W  = 4;
  localparam int DW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: handshake flags plus the arithmetic result of the
  // operation currently owned by the divider.
  bit     m_in_ready  = 1'b1;
  bit     m_out_valid = 1'b0;
  int     m_q, m_r, m_dbz, m_dividend, m_divisor;
  longint cyc = 0;
  longint m_ready_at = 0;

  seq_divider #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a normal divide is ready 2W edges after accept, a zero
  // divisor immediately; results come from plain / and %.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_ready  = 1'b1;
      m_out_valid = 1'b0;
    end else begin
      cyc++;
      if (m_in_ready && in_valid) begin
        m_in_ready = 1'b0;
        m_dividend = int'(dividend);
        m_divisor  = int'(divisor);
        if (divisor == 0) begin
          m_q         = (1 << DW) - 1;
          m_r         = m_dividend % (1 << W);
          m_dbz       = 1;
          m_out_valid = 1'b1;
        end else begin
          m_q        = m_dividend / m_divisor;
          m_r        = m_dividend % m_divisor;
          m_dbz      = 0;
          m_ready_at = cyc + DW;
        end
      end else if (m_out_valid && out_ready) begin
        m_out_valid = 1'b0;
        m_in_ready  = 1'b1;
      end else if (!m_in_ready && !m_out_valid && cyc == m_ready_at) begin
        m_out_valid = 1'b1;
      end
    end
  end

  // Every-cycle compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkValue("in_ready", in_ready, m_in_ready);
      checkValue("out_valid", out_valid, m_out_valid);
      if (m_out_valid) begin
        checkValue("quotient", quotient, m_q);
        checkValue("remainder", remainder, m_r);
        checkValue("div_by_zero", div_by_zero, m_dbz);
        if (m_dbz == 0) begin
          checkValue("identity", quotient * m_divisor + remainder, m_dividend);
          checkValue("rem_lt_div", remainder < m_divisor, 1);
        end
      end
    end
  end

  // Present one operation and hold it until accepted; inputs are scrambled
  // afterwards since they must only matter on the accept edge.
  task automatic applyStimulus(input logic [DW-1:0] dd, input logic [W-1:0] dv);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) checkValue("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = W'($urandom);
  endtask

  // Run one operation and compare against hand-computed literals; latency is
  // the number of edges after the accept edge until out_valid is seen.
  task automatic checkOutput(input string name, input logic [DW-1:0] dd, input logic [W-1:0] dv,
                             input int eq, input int er, input int edbz, input int elat);
    int n = 0;
    applyStimulus(dd, dv);
    if (elat > 0) checkValue({name, "_accepted"}, in_ready, 0);
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checkValue({name, "_latency"}, n, elat);
    checkValue({name, "_q"}, quotient, eq);
    checkValue({name, "_r"}, remainder, er);
    checkValue({name, "_dbz"}, div_by_zero, edbz);
  endtask

  task automatic takeResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Wait for the result with a random out_ready pattern until it is taken.
  task automatic drainWithStalls();
    int n = 0;
    bit done = 1'b0;
    bit hs;
    while (!done && n < 300) begin
      out_ready = ($urandom_range(0, 3) != 0);
      hs = out_valid && out_ready;
      @(posedge clk); #1;
      n++;
      done = hs;
    end
    out_ready = 1'b0;
    checkValue("exh_done", done, 1);
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by the exhaustive sweep.
  initial begin
    logic [DW-1:0] hq;
    logic [W-1:0]  hr;

    #12;
    rst_n = 1'b1;
    checkValue("reset_in_ready", in_ready, 1);
    checkValue("reset_out_valid", out_valid, 0);
    checkValue("reset_quotient", quotient, 0);
    checkValue("reset_remainder", remainder, 0);
    checkValue("reset_dbz", div_by_zero, 0);
    @(posedge clk); #1;

    checkOutput("d200_7", 8'd200, 4'd7, 28, 4, 0, 8);
    takeResult();
    checkOutput("d255_1", 8'd255, 4'd1, 255, 0, 0, 8);
    takeResult();
    checkOutput("d15_15", 8'd15, 4'd15, 1, 0, 0, 8);
    takeResult();
    checkOutput("d0_9", 8'd0, 4'd9, 0, 0, 0, 8);
    takeResult();
    checkOutput("d14_15", 8'd14, 4'd15, 0, 14, 0, 8);
    takeResult();
    checkOutput("dbz", 8'h3C, 4'd0, 255, 12, 1, 0);
    takeResult();

    // Backpressure: hold DONE for 10 cycles while in_valid pulses with junk.
    checkOutput("bp", 8'd200, 4'd7, 28, 4, 0, 8);
    hq = quotient;
    hr = remainder;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = DW'($urandom);
      divisor  = W'($urandom);
      @(posedge clk); #1;
      checkValue("bp_hold_q", quotient, 28);
      checkValue("bp_hold_r", remainder, 4);
      checkValue("bp_in_ready", in_ready, 0);
      checkValue("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    checkValue("bp_q_stable", quotient, hq);
    checkValue("bp_r_stable", remainder, hr);
    takeResult();
    checkValue("bp_idle_in_ready", in_ready, 1);
    checkValue("bp_idle_out_valid", out_valid, 0);
    checkOutput("after_bp", 8'd15, 4'd15, 1, 0, 0, 8);
    takeResult();

    // Reset in the middle of RUN, after three steps.
    applyStimulus(8'd200, 4'd7);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkValue("rst_mid_in_ready", in_ready, 1);
    checkValue("rst_mid_out_valid", out_valid, 0);
    checkValue("rst_mid_quotient", quotient, 0);
    checkValue("rst_mid_remainder", remainder, 0);
    checkValue("rst_mid_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("d100_3", 8'd100, 4'd3, 33, 1, 0, 8);
    takeResult();

    // Every dividend against every nonzero divisor, with random consumer stalls.
    for (int dv = 1; dv < (1 << W); dv++) begin
      for (int dd = 0; dd < (1 << DW); dd++) begin
        applyStimulus(DW'(dd), W'(dv));
        drainWithStalls();
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
